// File: rtl/pattern_detector_param.sv
// pattern_detector_param
// Serial pattern detector with a loadable PAT_W-bit pattern, selectable
// overlapping/non-overlapping detection and a registered one-cycle match
// pulse. An optional saturating match counter is built only when the macro
// PD_MATCH_COUNT_EN is defined; otherwise match_cnt is tied to zero.
module pattern_detector_param #(
  parameter int                PAT_W    = 6,
  parameter logic [PAT_W-1:0]  PAT_INIT = 6'b110100,
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  input  logic              in_valid,
  input  logic              overlap,
  input  logic              load,
  input  logic [PAT_W-1:0]  pat_in,
  output logic              y,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int                FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q,   pat_d;
  logic [PAT_W-2:0]   hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic               y_q,     y_d;
  logic [PAT_W-1:0]   window;
  logic               match;

  // Registers the detector state; reset restores the power-on pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      fill_q  <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_q     <= y_d;
    end
  end

  // Next-state logic: load wins over data, idle cycles hold everything.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    match  = 1'b0;
    window = {hist_q, x};

    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      match = (state_q == ARMED) && (window == pat_q);
      y_d   = match;
      if (match && !overlap) begin
        // Non-overlapping: the completing bit is consumed by this match.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      end
    end

    state_d = (fill_d == FILL_MAX) ? ARMED : FILL;
  end

  assign y = y_q;

`ifdef PD_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter, cleared by reset and by a pattern load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter next value: clear on load, bump on match unless already full.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench for pattern_detector_param. Two instances share one input
// stream: the default configuration and a CNT_W=2 copy for saturation.
module tb_pattern_detector_param;

`ifdef PD_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       load = 1'b0;
  logic [5:0] pat_in = '0;
  logic       y, y2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int nchk = 0;
  int nerr = 0;

  pattern_detector_param dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .y(y), .match_cnt(match_cnt)
  );

  pattern_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .y(y2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // One clock with the given bit; outputs sampled 1ns after the edge.
  task automatic step(input logic xb, input logic v);
    @(negedge clk);
    x = xb; in_valid = v; load = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; load = 1'b1; pat_in = 6'b000111; in_valid = 1'b1; x = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] p);
    @(negedge clk);
    load = 1'b1; pat_in = p; in_valid = 1'b1; x = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0; in_valid = 1'b0;
    chk("load_y", y, 0);
    chk("load_cnt", match_cnt, 0);
  endtask

  // Sends n bits MSB-first; ymask (MSB-first) gives the expected y per bit.
  task automatic send(input string tag, input logic [31:0] bits, input int n,
                      input logic [31:0] ymask);
    for (int k = n - 1; k >= 0; k--) begin
      step(bits[k], 1'b1);
      chk(tag, y, ymask[k]);
      chk({tag, "_y2"}, y2, ymask[k]);
    end
  endtask

  initial begin
    // Reset state, with load asserted to confirm rst priority
    do_rst();
    do_rst();
    chk("rst_y", y, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_cnt2", match_cnt2, 0);

    // Default pattern, single match
    overlap = 1'b1;
    send("basic", 32'b110100, 6, 32'b000001);
    chk("basic_cnt", match_cnt, ecnt(1));
    step(1'b0, 1'b0);
    chk("basic_idle_y", y, 0);

    // Alternating pattern, overlapping
    do_load(6'b101010);
    send("ovl", 32'b10101010, 8, 32'b00000101);
    chk("ovl_cnt", match_cnt, ecnt(2));

    // Alternating pattern, non-overlapping
    do_load(6'b101010);
    overlap = 1'b0;
    send("novl", 32'b10101010, 8, 32'b00000100);
    chk("novl_cnt", match_cnt, ecnt(1));

    // Idle cycles between every bit, junk on x while idle
    overlap = 1'b1;
    do_load(6'b110100);
    for (int k = 5; k >= 0; k--) begin
      logic [5:0] p;
      p = 6'b110100;
      step(p[k], 1'b1);
      chk("gap_valid_y", y, (k == 0));
      step(1'($urandom_range(0, 1)), 1'b0);
      chk("gap_idle_y", y, 0);
    end
    chk("gap_cnt", match_cnt, ecnt(1));

    // Load mid-pattern discards history
    send("ldmid_pre", 32'b11010, 5, 32'b0);
    do_load(6'b110100);
    step(1'b0, 1'b1);
    chk("ldmid_y", y, 0);
    chk("ldmid_cnt", match_cnt, 0);

    // Reset mid-pattern discards history, then full pattern matches
    do_load(6'b110100);
    send("rstmid_pre", 32'b11010, 5, 32'b0);
    do_rst();
    chk("rstmid_rst_y", y, 0);
    step(1'b0, 1'b1);
    chk("rstmid_y", y, 0);
    send("rstmid_full", 32'b110100, 6, 32'b000001);
    chk("rstmid_cnt", match_cnt, ecnt(1));

    // Back-to-back non-overlapping matches, 2-bit counter saturates
    do_rst();
    overlap = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send("b2b", 32'b110100, 6, 32'b000001);
      chk("b2b_cnt2", match_cnt2, ecnt((i > 3) ? 3 : i));
      chk("b2b_cnt", match_cnt, ecnt(i));
    end
    step(1'b0, 1'b0);
    chk("b2b_idle_y", y, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pattern_detector_param.md
PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
- REQ-001: Parameter PAT_W, default 6, pattern length in bits; legal range 2..32.
- REQ-002: Parameter PAT_INIT, default 6'b110100, pattern held after reset (PAT_W bits).
- REQ-003: Parameter CNT_W, default 8, width of the match counter.
- REQ-004: Port clk, input, 1, single clock; all state SHALL update on its rising edge.
- REQ-005: Port rst, input, 1, synchronous active-high reset.
- REQ-006: Port x, input, 1, serial data bit.
- REQ-007: Port in_valid, input, 1, x is sampled only when high.
- REQ-008: Port overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- REQ-009: Port load, input, 1, strobe to load a new pattern from pat_in.
- REQ-010: Port pat_in, input, PAT_W, new pattern; bit PAT_W-1 is the first bit expected on x.
- REQ-011: Port y, output, 1, registered one-cycle match pulse.
- REQ-012: Port match_cnt, output, CNT_W, saturating count of matches.

Function
- REQ-013: The block SHALL hold pattern register pat_reg, history register hist (PAT_W-1 bits, newest bit in LSB) and fill counter fill (0..PAT_W-1).
- REQ-014: FSM states: FILL (fill < PAT_W-1) and ARMED (fill == PAT_W-1); the block SHALL only evaluate matches in ARMED.
- REQ-015: On each cycle with in_valid=1 and load=0, x SHALL shift into hist; fill SHALL increment and saturate at PAT_W-1, moving FILL -> ARMED.
- REQ-016: A match SHALL be {hist, x} == pat_reg while in ARMED with in_valid=1 and load=0.
- REQ-017: y SHALL be 1 in exactly the cycle after the sampling edge of the completing bit (latency 1); otherwise 0.
- REQ-018: Cycles with in_valid=0 SHALL leave hist, fill and match_cnt unchanged and drive y=0 in the following cycle.
- REQ-019: overlap=1: on a match, hist and fill SHALL update normally, so the tail of a match can begin the next one.
- REQ-020: overlap=0: on a match, hist and fill SHALL clear to 0 (return to FILL); the matching bit is not reused.
- REQ-021: overlap SHALL be sampled per bit; changing it mid-stream affects only the matches that follow.
- REQ-022: load=1 SHALL copy pat_in into pat_reg, clear hist, fill and match_cnt, force y=0 next cycle, and ignore x that cycle.
- REQ-023: match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1, never wrapping.
- REQ-024: Simultaneous rst and load: rst SHALL take priority.

Reset
- REQ-025: With rst=1 at a clock edge, the block SHALL set pat_reg=PAT_INIT, hist=0, fill=0 (FILL), y=0 and match_cnt=0.
- REQ-026: Reset mid-pattern SHALL discard all partial history; no match is reported from bits sampled before reset.

Configuration
- REQ-027: Macro PD_MATCH_COUNT_EN defined: the match counter SHALL be implemented as specified.
- REQ-028: Macro PD_MATCH_COUNT_EN undefined: no counter logic is built and match_cnt SHALL be constant 0; all other behaviour is unchanged.

Verification
- REQ-029: Defaults, rst pulse, overlap=1, x stream 1,1,0,1,0,0 with in_valid=1 -> y=1 only in the cycle after the 6th bit; match_cnt=1.
- REQ-030: load pat_in=6'b101010, stream 1,0,1,0,1,0,1,0: overlap=1 -> y pulses after bits 6 and 8, match_cnt=2; overlap=0 -> one pulse after bit 6, match_cnt=1.
- REQ-031: Stream 110100 with in_valid=0 idle cycles between every bit -> single y pulse after the 6th valid bit; y=0 during idle cycles.
- REQ-032: Send 1,1,0,1,0, then load=1 with pat_in=6'b110100, then x=0 -> no y pulse; match_cnt=0.
- REQ-033: CNT_W=2, overlap=0, four back-to-back 110100 patterns -> four y pulses; match_cnt sequence 1,2,3,3.
- REQ-034: Send 1,1,0,1,0, assert rst for one cycle, then x=0 -> no y pulse; the full 110100 sent afterwards -> y=1; with PD_MATCH_COUNT_EN undefined, match_cnt stays 0 throughout.
